// File: rtl/shift_seq_pkg.sv
// Shared ctrl encodings and sequencer state encoding for the univ_shift_reg sequencer.
// The ctrl constants are reused by every producer of univ_shift_reg ctrl words.
package shift_seq_pkg;

    localparam logic [1:0] CTRL_LOAD = 2'b00;
    localparam logic [1:0] CTRL_SHL  = 2'b10;
    localparam logic [1:0] CTRL_SHR  = 2'b01;
    localparam logic [1:0] CTRL_HOLD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/shift_seq_cnt.sv
// Remaining-shift counter: saturates to DW when loaded, counts down on dec_i, never underflows.
// zero_o/last_o decode the registered count so the FSM sees them without extra latency.
module shift_seq_cnt #(
    parameter int DW = 4,
    parameter int CW = $clog2(DW) + 1
) (
    input  logic          clk,
    input  logic          async_rst_n,
    input  logic          load_i,
    input  logic [CW-1:0] cnt_i,
    input  logic          dec_i,
    output logic          zero_o,
    output logic          last_o
);

    localparam logic [CW-1:0] DW_C = CW'(DW);

    logic [CW-1:0] rem_q;
    logic [CW-1:0] rem_d;

    always_comb begin
        rem_d = rem_q;
        if (load_i) begin
            rem_d = (cnt_i > DW_C) ? DW_C : cnt_i;
        end else if (dec_i && (rem_q != '0)) begin
            rem_d = rem_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            rem_q <= '0;
        end else begin
            rem_q <= rem_d;
        end
    end

    assign zero_o = (rem_q == '0);
    assign last_o = (rem_q == CW'(1));

endmodule

// File: rtl/shift_seq_ctrl.sv
// Sequencer for univ_shift_reg: accepts a job, issues one load, cnt_eff shifts, then a done pulse.
// Optional macro SHIFT_SEQ_ROTATE_EN adds in_rot/q_msb/q_lsb to feed the live end bit back as fill.
module shift_seq_ctrl
    import shift_seq_pkg::*;
#(
    parameter int DW = 4,
    parameter int CW = $clog2(DW) + 1
) (
    input  logic          clk,
    input  logic          async_rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic          in_dir,
    input  logic [CW-1:0] in_cnt,
    input  logic          in_fill,
`ifdef SHIFT_SEQ_ROTATE_EN
    input  logic          in_rot,
    input  logic          q_msb,
    input  logic          q_lsb,
`endif
    output logic [1:0]    ctrl,
    output logic [DW-1:0] data,
    output logic          data_l,
    output logic          data_h,
    output logic          busy,
    output logic          done
);

    state_e        state_q;
    state_e        state_d;
    logic [DW-1:0] data_q;
    logic          dir_q;
    logic          fill_q;
    logic          accept;
    logic          cnt_zero;
    logic          cnt_last;
    logic          fill_l;
    logic          fill_r;

    assign accept = in_valid && (state_q == ST_IDLE);

    shift_seq_cnt #(
        .DW (DW),
        .CW (CW)
    ) u_cnt (
        .clk         (clk),
        .async_rst_n (async_rst_n),
        .load_i      (accept),
        .cnt_i       (in_cnt),
        .dec_i       (state_q == ST_SHIFT),
        .zero_o      (cnt_zero),
        .last_o      (cnt_last)
    );

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            data_q <= '0;
            dir_q  <= 1'b0;
            fill_q <= 1'b0;
        end else if (accept) begin
            data_q <= in_data;
            dir_q  <= in_dir;
            fill_q <= in_fill;
        end
    end

`ifdef SHIFT_SEQ_ROTATE_EN
    logic rot_q;

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            rot_q <= 1'b0;
        end else if (accept) begin
            rot_q <= in_rot;
        end
    end

    // Rotate takes the bit leaving the register this cycle, straight from live q.
    assign fill_l = rot_q ? q_msb : fill_q;
    assign fill_r = rot_q ? q_lsb : fill_q;
`else
    assign fill_l = fill_q;
    assign fill_r = fill_q;
`endif

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ctrl     = CTRL_HOLD;
        busy     = 1'b0;
        done     = 1'b0;
        in_ready = 1'b0;
        data_l   = 1'b0;
        data_h   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (accept) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                ctrl    = CTRL_LOAD;
                busy    = 1'b1;
                state_d = cnt_zero ? ST_DONE : ST_SHIFT;
            end
            ST_SHIFT: begin
                busy = 1'b1;
                if (dir_q) begin
                    ctrl   = CTRL_SHR;
                    data_h = fill_r;
                end else begin
                    ctrl   = CTRL_SHL;
                    data_l = fill_l;
                end
                if (cnt_last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign data = data_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl with a behavioural univ_shift_reg and a per-job expected-cycle queue.
// Build with SHIFT_SEQ_ROTATE_EN defined to also exercise rotate jobs.
module tb_shift_seq_ctrl;

    localparam int DW = 4;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          async_rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_dir = 1'b0;
    logic [CW-1:0] in_cnt = '0;
    logic          in_fill = 1'b0;
    logic          in_ready;
    logic [1:0]    ctrl;
    logic [DW-1:0] data;
    logic          data_l;
    logic          data_h;
    logic          busy;
    logic          done;
    logic [DW-1:0] reg_q = '0;
    logic          rot_in;

`ifdef SHIFT_SEQ_ROTATE_EN
    logic in_rot = 1'b0;
    logic q_msb;
    logic q_lsb;
    assign q_msb  = reg_q[DW-1];
    assign q_lsb  = reg_q[0];
    assign rot_in = in_rot;
`else
    assign rot_in = 1'b0;
`endif

    shift_seq_ctrl #(.DW(DW), .CW(CW)) dut (
        .clk         (clk),
        .async_rst_n (async_rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_dir      (in_dir),
        .in_cnt      (in_cnt),
        .in_fill     (in_fill),
`ifdef SHIFT_SEQ_ROTATE_EN
        .in_rot      (in_rot),
        .q_msb       (q_msb),
        .q_lsb       (q_lsb),
`endif
        .ctrl        (ctrl),
        .data        (data),
        .data_l      (data_l),
        .data_h      (data_h),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // Downstream universal shift register driven by the DUT.
    always @(posedge clk) begin
        case (ctrl)
            2'b00:   reg_q <= data;
            2'b10:   reg_q <= {reg_q[DW-2:0], data_l};
            2'b01:   reg_q <= {data_h, reg_q[DW-1:1]};
            default: reg_q <= reg_q;
        endcase
    end

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // kind: 0 = load cycle, 1 = shift cycle, 2 = done cycle
    typedef struct {
        int            kind;
        logic          dir;
        logic          fill;
        logic          rot;
        logic [DW-1:0] d;
        logic [DW-1:0] fq;
    } ent_t;

    ent_t mq[$];

    function automatic void push_job(logic [DW-1:0] d, logic dir, logic [CW-1:0] cnt,
                                     logic fill, logic rot);
        int n;
        logic [DW-1:0] v;
        ent_t e;
        n = (int'(cnt) > DW) ? DW : int'(cnt);
        v = d;
        for (int i = 0; i < n; i++) begin
            if (!dir) v = {v[DW-2:0], rot ? v[DW-1] : fill};
            else      v = {rot ? v[0] : fill, v[DW-1:1]};
        end
        e.dir = dir; e.fill = fill; e.rot = rot; e.d = d; e.fq = v;
        e.kind = 0; mq.push_back(e);
        e.kind = 1;
        for (int i = 0; i < n; i++) mq.push_back(e);
        e.kind = 2; mq.push_back(e);
    endfunction

    // Reference: an empty queue means idle; each accept enqueues the job's whole cycle list.
    always @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            mq.delete();
        end else if (mq.size() != 0) begin
            mq.delete(0);
        end else if (in_valid) begin
            push_job(in_data, in_dir, in_cnt, in_fill, rot_in);
        end
    end

    always @(negedge clk) begin
        if (async_rst_n) begin
            if (mq.size() == 0) begin
                chk("idle_ctrl", 32'(ctrl), 32'h3);
                chk("idle_ready", 32'(in_ready), 32'h1);
                chk("idle_busy", 32'(busy), 32'h0);
                chk("idle_done", 32'(done), 32'h0);
            end else begin
                chk("job_ready", 32'(in_ready), 32'h0);
                case (mq[0].kind)
                    0: begin
                        chk("load_ctrl", 32'(ctrl), 32'h0);
                        chk("load_data", 32'(data), 32'(mq[0].d));
                        chk("load_busy", 32'(busy), 32'h1);
                        chk("load_done", 32'(done), 32'h0);
                    end
                    1: begin
                        chk("shift_ctrl", 32'(ctrl), mq[0].dir ? 32'h1 : 32'h2);
                        chk("shift_busy", 32'(busy), 32'h1);
                        chk("shift_done", 32'(done), 32'h0);
                        chk("shift_dl", 32'(data_l), mq[0].dir ? 32'h0 :
                            32'(mq[0].rot ? reg_q[DW-1] : mq[0].fill));
                        chk("shift_dh", 32'(data_h), !mq[0].dir ? 32'h0 :
                            32'(mq[0].rot ? reg_q[0] : mq[0].fill));
                    end
                    default: begin
                        chk("done_ctrl", 32'(ctrl), 32'h3);
                        chk("done_busy", 32'(busy), 32'h0);
                        chk("done_done", 32'(done), 32'h1);
                        chk("final_q", 32'(reg_q), 32'(mq[0].fq));
                    end
                endcase
            end
        end
    end

    // Starts at a negedge with the DUT idle; returns at the negedge of the done cycle.
    task automatic run_job(input logic [DW-1:0] d, input logic dir, input logic [CW-1:0] cnt,
                           input logic fill, input logic rot, output int cyc);
        @(negedge clk);
        in_data = d; in_dir = dir; in_cnt = cnt; in_fill = fill;
`ifdef SHIFT_SEQ_ROTATE_EN
        in_rot = rot;
`else
        if (rot) $display("note: rotate requested without SHIFT_SEQ_ROTATE_EN");
`endif
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        cyc = 1;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        if (!done) chk("done_timeout", 32'h0, 32'h1);
    endtask

    int cyc;
    logic rdy_seq [0:8];
    logic done_seq [0:8];
    logic [DW-1:0] q_at_done;

    initial begin
        #1;
        chk("rst_ctrl", 32'(ctrl), 32'h3);
        chk("rst_data", 32'(data), 32'h0);
        chk("rst_dl", 32'(data_l), 32'h0);
        chk("rst_dh", 32'(data_h), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_ready", 32'(in_ready), 32'h1);
        #11;
        async_rst_n = 1'b1;

        run_job(4'b1011, 1'b0, 3'd2, 1'b0, 1'b0, cyc);
        chk("t1_cycles", 32'(cyc), 32'd4);
        chk("t1_q", 32'(reg_q), 32'b1100);

        run_job(4'b0010, 1'b1, 3'd3, 1'b1, 1'b0, cyc);
        chk("t2_cycles", 32'(cyc), 32'd5);
        chk("t2_q", 32'(reg_q), 32'b1110);

        run_job(4'b0101, 1'b0, 3'd0, 1'b1, 1'b0, cyc);
        chk("t3_cycles", 32'(cyc), 32'd2);
        chk("t3_q", 32'(reg_q), 32'b0101);

        // Saturation with in_valid held high across two jobs.
        @(negedge clk);
        in_data = 4'b0000; in_dir = 1'b0; in_cnt = 3'd7; in_fill = 1'b1;
`ifdef SHIFT_SEQ_ROTATE_EN
        in_rot = 1'b0;
`endif
        in_valid = 1'b1;
        q_at_done = '0;
        for (int i = 0; i < 9; i++) begin
            if (i > 0) @(negedge clk);
            rdy_seq[i] = in_ready;
            done_seq[i] = done;
            if (i == 6) q_at_done = reg_q;
        end
        in_valid = 1'b0;
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("t4_ready%0d", i), 32'(rdy_seq[i]), (i == 0 || i == 7) ? 32'h1 : 32'h0);
            chk($sformatf("t4_done%0d", i), 32'(done_seq[i]), (i == 6) ? 32'h1 : 32'h0);
        end
        chk("t4_q", 32'(q_at_done), 32'b1111);
        cyc = 0;
        while (!in_ready && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk("t4_drain", 32'(in_ready), 32'h1);

        // Reset during the second shift cycle.
        @(negedge clk);
        in_data = 4'b1001; in_dir = 1'b0; in_cnt = 3'd3; in_fill = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2;
        async_rst_n = 1'b0;
        #1;
        chk("t5_ctrl", 32'(ctrl), 32'h3);
        chk("t5_busy", 32'(busy), 32'h0);
        chk("t5_done", 32'(done), 32'h0);
        chk("t5_ready", 32'(in_ready), 32'h1);
        @(negedge clk);
        #2;
        async_rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("t5_nodone%0d", i), 32'(done), 32'h0);
        end
        chk("t5_ready_after", 32'(in_ready), 32'h1);

`ifdef SHIFT_SEQ_ROTATE_EN
        run_job(4'b1000, 1'b0, 3'd1, 1'b0, 1'b1, cyc);
        chk("t6_cycles1", 32'(cyc), 32'd3);
        chk("t6_q1", 32'(reg_q), 32'b0001);
        run_job(4'b1000, 1'b0, 3'd4, 1'b0, 1'b1, cyc);
        chk("t6_cycles4", 32'(cyc), 32'd6);
        chk("t6_q4", 32'(reg_q), 32'b1000);
`endif

        // Random jobs; in_* churn every cycle, including while busy.
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            in_valid = ($urandom_range(0, 3) != 0);
            in_data  = DW'($urandom);
            in_dir   = 1'($urandom);
            in_cnt   = CW'($urandom_range(0, 7));
            in_fill  = 1'($urandom);
`ifdef SHIFT_SEQ_ROTATE_EN
            in_rot   = 1'($urandom);
`endif
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (12) @(negedge clk);
        chk("end_idle", 32'(in_ready), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
